dmem_port_ctrl: RTL

DMEM_PORT_CTRL -- requirements
Module: dmem_port_ctrl

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_resp_fifo.sv | 50 +++++
 rtl/dmem_port_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared default widths and response entry layout for the data-memory port
package dmem_pkg;

    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_ADDR_WIDTH = 8;
    localparam int DMEM_TAG_WIDTH  = 4;

    typedef struct packed {
        logic [DMEM_DATA_WIDTH-1:0] data;
        logic [DMEM_TAG_WIDTH-1:0]  tag;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_resp_fifo.sv
// rtl/dmem_resp_fifo.sv - in-order synchronous response FIFO with occupancy count
module dmem_resp_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/dmem_port_ctrl.sv
// rtl/dmem_port_ctrl.sv - request/response front end for a 1W/1R SRAM macro with tagged loads
module dmem_port_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int TAG_WIDTH  = DMEM_TAG_WIDTH,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic                            store_acc;
    logic                            load_acc;
    logic                            load_credit;
    logic                            inflight;
    logic [TAG_WIDTH-1:0]            tag_q;
    logic [CW-1:0]                   fifo_count;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_head;

    // A slot freed by this cycle's pop is not reused until next cycle; the
    // load whose data is still on dout1 already owns a slot.
    assign load_credit = (32'(fifo_count) + 32'(inflight)) < 32'(RESP_DEPTH);

    assign req_ready = !reset && (req_we || load_credit);
    assign store_acc = req_valid && req_we && !reset;
    assign load_acc  = req_valid && !req_we && !reset && load_credit;

    assign csb0  = !store_acc;
    assign addr0 = store_acc ? req_addr : '0;
    assign din0  = store_acc ? req_wdata : '0;
    assign csb1  = !load_acc;
    assign addr1 = load_acc ? req_addr : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            tag_q    <= '0;
        end else begin
            inflight <= load_acc;
            if (load_acc) begin
                tag_q <= req_tag;
            end
        end
    end

    dmem_resp_fifo #(
        .WIDTH(DATA_WIDTH + TAG_WIDTH),
        .DEPTH(RESP_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .push_data({dout1, tag_q}),
        .pop      (resp_valid && resp_ready),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign resp_valid = !reset && (fifo_count != '0);
    assign resp_data  = resp_valid ? fifo_head[TAG_WIDTH +: DATA_WIDTH] : '0;
    assign resp_tag   = resp_valid ? fifo_head[TAG_WIDTH-1:0] : '0;

endmodule
